// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
//   Stimulus/capture stage for a 3-input combinational gate network.
//   On start it drives every input vector 0..2**N_IN-1, holding each for
//   HOLD_CYCLES cycles so the network can settle, samples the returned F in
//   the last hold cycle into table_out, and counts the bits that disagree
//   with the golden EXPECTED table.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   start      in   one-cycle sweep request (accepted in IDLE or DONE)
//   vec        out  vector driven to the network (MSB = x, LSB = z)
//   f_in       in   F returned by the network under test
//   busy       out  high while the sweep is running
//   done       out  high once the sweep has finished, until the next start
//   table_out  out  captured truth table, bit i = F for vec == i
//   err_count  out  number of bits where table_out differs from EXPECTED
//   pass       out  done and no mismatches
// ---------------------------------------------------------------------------
module truth_table_sweeper #(
  parameter int N_IN        = 3,
  parameter int HOLD_CYCLES = 4,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'hAC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      vec,
  input  logic                 f_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        err_count,
  output logic                 pass
);

  localparam int NV = 2**N_IN;
  // Keep the hold counter at least one bit wide so HOLD_CYCLES == 1 still
  // elaborates; in that build the counter simply stays at zero.
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);
  localparam logic [N_IN-1:0] VEC_LAST  = N_IN'(NV - 1);
  localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE   = (N_IN+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [N_IN-1:0] vec_reg, vec_next;
  logic [HW-1:0]   hold_reg, hold_next;
  logic [NV-1:0]   table_reg, table_next;
  logic [N_IN:0]   err_reg, err_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      vec_reg   <= '0;
      hold_reg  <= '0;
      table_reg <= '0;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      vec_reg   <= vec_next;
      hold_reg  <= hold_next;
      table_reg <= table_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    vec_next   = vec_reg;
    hold_next  = hold_reg;
    table_next = table_reg;
    err_next   = err_reg;

    case (state_reg)
      // DONE restarts exactly like IDLE; results stay visible until then.
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_DRIVE;
          vec_next   = '0;
          hold_next  = '0;
          table_next = '0;
          err_next   = '0;
        end
      end

      // start is deliberately not looked at here: a running sweep cannot be
      // restarted or extended.
      S_DRIVE: begin
        if (hold_reg == HOLD_LAST) begin
          // Last settle cycle of this vector: capture F and score it.
          hold_next           = '0;
          table_next[vec_reg] = f_in;
          if (f_in != EXPECTED[vec_reg]) begin
            err_next = err_reg + ERR_ONE;
          end
          if (vec_reg == VEC_LAST) begin
            state_next = S_DONE;   // vec stays at its final value
          end else begin
            vec_next = vec_reg + VEC_ONE;
          end
        end else begin
          hold_next = hold_reg + HOLD_ONE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign vec       = vec_reg;
  assign busy      = (state_reg == S_DRIVE);
  assign done      = (state_reg == S_DONE);
  assign table_out = table_reg;
  assign err_count = err_reg;
  assign pass      = done && (err_reg == '0);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// tb_truth_table_sweeper
//   Directed bench for truth_table_sweeper. Two instances: the default build
//   (HOLD_CYCLES = 4) and a HOLD_CYCLES = 1 build. A behavioural model of the
//   gate network F = x'y + xz answers each instance's vec, with selectable
//   faults (stuck-0, stuck-1, forced 1 at vec=4, early-cycle glitches).
// ---------------------------------------------------------------------------
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start1;
  logic [2:0] vec, vec1;
  logic       f_in, f_in1;
  logic       busy, busy1, done, done1, pass, pass1;
  logic [7:0] table_out, table_out1;
  logic [3:0] err_count, err_count1;

  int   tests = 0;
  int   fails = 0;
  int   mode  = 0;      // 0 golden, 1 stuck-0, 2 stuck-1, 3 golden but F=1 at vec=4
  logic glitch = 1'b0;  // corrupts golden F outside the sampling cycle

  function automatic logic f_gold(input logic [2:0] v);
    return (~v[2] & v[1]) | (v[2] & v[0]);
  endfunction

  always_comb begin
    case (mode)
      1:       f_in = 1'b0;
      2:       f_in = 1'b1;
      3:       f_in = f_gold(vec) | (vec == 3'd4);
      default: f_in = f_gold(vec) ^ glitch;
    endcase
  end
  assign f_in1 = f_gold(vec1);

  truth_table_sweeper dut (
    .clk(clk), .rst(rst), .start(start), .vec(vec), .f_in(f_in),
    .busy(busy), .done(done), .table_out(table_out),
    .err_count(err_count), .pass(pass)
  );

  truth_table_sweeper #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .vec(vec1), .f_in(f_in1),
    .busy(busy1), .done(done1), .table_out(table_out1),
    .err_count(err_count1), .pass(pass1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ends 1 ns after the accepting edge k (sweep cycle 0).
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Advance sweep cycles from..to-1; glitch F in every non-sampling cycle.
  task automatic run_cycles(input int from, input int to);
    for (int j = from; j < to; j++) begin
      glitch = ((j % 4) != 3);
      tick();
    end
    glitch = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    tick(); tick();
    tests++; if (vec !== 3'd0)       begin fails++; $display("FAIL reset_vec got=%0d exp=0", vec); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0)      begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests++; if (table_out !== 8'h00) begin fails++; $display("FAIL reset_table got=%h exp=00", table_out); end
    tests++; if (err_count !== 4'd0) begin fails++; $display("FAIL reset_err got=%0d exp=0", err_count); end
    tests++; if (pass !== 1'b0)      begin fails++; $display("FAIL reset_pass got=%b exp=0", pass); end
    rst = 1'b0;
    tick();
    $display("[TB] reset: vec=%0d busy=%b done=%b table=%h err=%0d", vec, busy, done, table_out, err_count);
  endtask

  task automatic test_golden();
    mode = 0;
    pulse_start();
    run_cycles(0, 31);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL golden_done_early got=%b exp=0 at cycle 31", done); end
    run_cycles(31, 32);
    tests++; if (done !== 1'b1)       begin fails++; $display("FAIL golden_done got=%b exp=1 at cycle 32", done); end
    tests++; if (table_out !== 8'hAC) begin fails++; $display("FAIL golden_table got=%h exp=ac", table_out); end
    tests++; if (err_count !== 4'd0)  begin fails++; $display("FAIL golden_err got=%0d exp=0", err_count); end
    tests++; if (pass !== 1'b1)       begin fails++; $display("FAIL golden_pass got=%b exp=1", pass); end
    tests++; if (vec !== 3'd7)        begin fails++; $display("FAIL golden_vec_hold got=%0d exp=7", vec); end
    $display("[TB] golden sweep: table=%h err=%0d pass=%b", table_out, err_count, pass);
  endtask

  task automatic test_tied();
    mode = 1;
    pulse_start();
    run_cycles(0, 32);
    tests++; if (table_out !== 8'h00) begin fails++; $display("FAIL tied0_table got=%h exp=00", table_out); end
    tests++; if (err_count !== 4'd4)  begin fails++; $display("FAIL tied0_err got=%0d exp=4", err_count); end
    tests++; if (pass !== 1'b0)       begin fails++; $display("FAIL tied0_pass got=%b exp=0", pass); end
    $display("[TB] tied-0 sweep: table=%h err=%0d pass=%b", table_out, err_count, pass);
    mode = 2;
    pulse_start();
    run_cycles(0, 32);
    tests++; if (table_out !== 8'hFF) begin fails++; $display("FAIL tied1_table got=%h exp=ff", table_out); end
    tests++; if (err_count !== 4'd4)  begin fails++; $display("FAIL tied1_err got=%0d exp=4", err_count); end
    $display("[TB] tied-1 sweep: table=%h err=%0d pass=%b", table_out, err_count, pass);
  endtask

  task automatic test_vec_sequence();
    int bad = 0;
    mode = 3;
    pulse_start();
    for (int j = 0; j < 32; j++) begin
      tests++;
      if (vec !== 3'(j / 4) || busy !== 1'b1) begin
        fails++; bad++;
        $display("FAIL vec_seq cycle=%0d got vec=%0d busy=%b exp vec=%0d busy=1", j, vec, busy, j / 4);
      end
      tick();
    end
    tests++; if (busy !== 1'b0 || done !== 1'b1) begin fails++; $display("FAIL vec_seq_end got busy=%b done=%b exp busy=0 done=1", busy, done); end
    tests++; if (table_out !== 8'hBC) begin fails++; $display("FAIL forced4_table got=%h exp=bc", table_out); end
    tests++; if (err_count !== 4'd1)  begin fails++; $display("FAIL forced4_err got=%0d exp=1", err_count); end
    $display("[TB] vec sequence: bad_cycles=%0d table=%h err=%0d", bad, table_out, err_count);
  endtask

  task automatic test_start_in_drive();
    mode = 1;
    pulse_start();
    for (int j = 0; j < 10; j++) tick();
    start = 1'b1;          // accepted edge would be cycle 11 if honoured
    tick();
    start = 1'b0;
    for (int j = 11; j < 31; j++) tick();
    tests++; if (done !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL drive_start_c31 got done=%b busy=%b exp done=0 busy=1", done, busy); end
    tick();
    tests++; if (done !== 1'b1)      begin fails++; $display("FAIL drive_start_done got=%b exp=1 at cycle 32", done); end
    tests++; if (err_count !== 4'd4) begin fails++; $display("FAIL drive_start_err got=%0d exp=4", err_count); end
    $display("[TB] start during drive: done=%b err=%0d", done, err_count);
    mode = 0;
    pulse_start();         // restart from DONE
    tests++; if (done !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL done_restart got done=%b busy=%b exp done=0 busy=1", done, busy); end
    tests++; if (vec !== 3'd0 || table_out !== 8'h00 || err_count !== 4'd0) begin
      fails++; $display("FAIL done_restart_clear got vec=%0d table=%h err=%0d exp 0/00/0", vec, table_out, err_count);
    end
    $display("[TB] start in done: done=%b busy=%b vec=%0d", done, busy, vec);
  endtask

  // Continues the sweep started at the end of test_start_in_drive.
  task automatic test_reset_mid();
    for (int j = 0; j < 13; j++) tick();
    tests++; if (vec !== 3'd3)        begin fails++; $display("FAIL mid_vec got=%0d exp=3", vec); end
    tests++; if (table_out !== 8'h04) begin fails++; $display("FAIL mid_table got=%h exp=04", table_out); end
    rst = 1'b1;
    #1;                    // no clock edge in between: reset must act asynchronously
    tests++; if (vec !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || table_out !== 8'h00 || err_count !== 4'd0 || pass !== 1'b0) begin
      fails++; $display("FAIL async_rst got vec=%0d busy=%b done=%b table=%h err=%0d pass=%b exp all 0",
                        vec, busy, done, table_out, err_count, pass);
    end
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    tests++; if (busy !== 1'b0 || done !== 1'b0 || vec !== 3'd0) begin
      fails++; $display("FAIL post_rst_idle got busy=%b done=%b vec=%0d exp 0/0/0", busy, done, vec);
    end
    $display("[TB] reset mid-sweep: vec=%0d busy=%b done=%b", vec, busy, done);
  endtask

  task automatic test_hold1();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tests++;
      if (vec1 !== 3'(j) || done1 !== 1'b0) begin
        fails++; $display("FAIL hold1_vec cycle=%0d got vec=%0d done=%b exp vec=%0d done=0", j, vec1, done1, j);
      end
      tick();
    end
    tests++; if (done1 !== 1'b1)       begin fails++; $display("FAIL hold1_done got=%b exp=1 at cycle 8", done1); end
    tests++; if (table_out1 !== 8'hAC) begin fails++; $display("FAIL hold1_table got=%h exp=ac", table_out1); end
    tests++; if (pass1 !== 1'b1 || err_count1 !== 4'd0) begin fails++; $display("FAIL hold1_pass got pass=%b err=%0d exp 1/0", pass1, err_count1); end
    $display("[TB] hold=1 sweep: table=%h err=%0d pass=%b", table_out1, err_count1, pass1);
  endtask

  initial begin
    test_reset();
    test_golden();
    test_tied();
    test_vec_sequence();
    test_start_in_drive();
    test_reset_mid();
    test_hold1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
